multiport_register_file: RTL and testbench
==========================================

// Module: multiport_register_file
// PURPOSE
// - Parametrised MIPS GPR file: NRD read ports, 2 write ports, $0 hardwired to zero, synchronous clear.
// - Optional same-cycle write->read bypass; optional registered read outputs (1-cycle latency).
// - Per-register pending scoreboard: decode marks a destination busy; writeback clears it. Feeds the hazard/stall unit.
// - Sits between decode (read addrs, pending set) and writeback (write ports) in the pipelined core.
// PARAMETERS
// - DW       32  data width, bits
// - NREG     32  number of registers, power of 2 (AW = $clog2(NREG))
// - NRD      2   number of read ports, 1..4
// - BYPASS   1   1: read of addr being written this cycle returns write data; 0: returns old value
// - RD_REG   0   0: combinational read; 1: read data registered, latency 1
// PORTS
// - clk         in   1         rising-edge clock
// - rst         in   1         synchronous, active-high reset
// - rd_addr     in   NRD*AW    packed read addresses, port i at [i*AW +: AW]
// - rd_data     out  NRD*DW    packed read data, port i at [i*DW +: DW]
// - rd_pend     out  NRD       1 = addressed register has a write pending
// - we0         in   1         write port 0 enable (ALU writeback)
// - wa0         in   AW        write port 0 address
// - wd0         in   DW        write port 0 data
// - we1         in   1         write port 1 enable (load writeback)
// - wa1         in   AW        write port 1 address
// - wd1         in   DW        write port 1 data
// - pend_set    in   1         mark pend_addr pending (decode issue)
// - pend_addr   in   AW        register to mark
// - any_pend    out  1         OR of all pending bits
// BEHAVIOUR
// - Reset: all registers 0, all pending bits 0; rd_data (RD_REG=1) 0, rd_pend 0, any_pend 0 on the cycle after rst.
// - rst has priority over every write/pend_set in the same cycle; reset mid-operation drops pending writes.
// - Writes take effect at rising clk; address 0 never written, always reads 0, never pending.
// - Dual-write collision (we0 & we1 & wa0==wa1 != 0): port 1 wins (later pipeline stage).
// - BYPASS=1: rd_data[i] = wd1 if we1 & wa1==rd_addr[i] != 0, else wd0 if we0 match, else stored value.
// - BYPASS=0: rd_data[i] = stored value; new data visible from the cycle after the write edge.
// - RD_REG=1: the above result is sampled at clk; rd_data valid one cycle after rd_addr presented.
// - Pending bit p[r]: next = (p[r] & ~cleared) | set, where cleared = write to r on either port,
//   set = pend_set & pend_addr==r. Set and clear same reg same cycle -> bit stays 1 (new producer issued).
// - rd_pend[i] = p[rd_addr[i]] & ~(write to rd_addr[i] this cycle when BYPASS=1); combinational, unregistered even if RD_REG=1.
// - any_pend = |p, registered view of current bits (no bypass).
// - Addresses >= NREG impossible (AW sized); no X propagation: unused read ports read 0 with addr 0.
// - Write-read same address, BYPASS=0, RD_REG=1: registered output holds old value; new value next read cycle.
// STRUCTURE
// - Shared package mips_pkg: DW, NREG, AW localparams; REG_ZERO = 0 constant; reg_addr_t typedef.
// - One sub-module natural: regfile_read_port (one per read port, generate loop) holding bypass mux,
//   optional output register and pending lookup; top holds storage array, write decode, scoreboard.
// TESTING
// - Reset: preload r5=55, pend r7; assert rst 1 cycle -> all rd_data 0, rd_pend 0, any_pend 0.
// - Basic: we0 wa0=1 wd0=55; next cycle rd_addr[0]=1 -> rd_data[0]=55; rd_addr[1]=0 -> 0.
// - $0: we0 wa0=0 wd0=32'hDEADBEEF -> read r0 = 0; pend_set r0 -> any_pend stays 0.
// - Collision: we0 wa0=3 wd0=10, we1 wa1=3 wd1=20 same cycle -> r3 = 20; bypass read that cycle = 20.
// - Bypass: BYPASS=1 read r4 while we0 writes 99 -> rd_data=99 same cycle; BYPASS=0 -> old value, 99 next cycle.
// - Scoreboard: pend_set r9 -> rd_pend=1, any_pend=1; we1 wa1=9 with pend_set r9 same cycle -> stays 1; lone write clears.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants: default data width, register count and
// the hardwired-zero register address.
package mips_pkg;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/multiport_register_file_read_port.sv
// One read port of the GPR file: write-to-read bypass, optional output
// register and pending-bit lookup for the hazard unit.
module regfile_read_port #(
  parameter int DW     = mips_pkg::DW,
  parameter int NREG   = mips_pkg::NREG,
  parameter int AW     = $clog2(NREG),
  parameter bit BYPASS = 1'b1,
  parameter bit RD_REG = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [DW-1:0]   stored_i,
  input  logic [NREG-1:0] pend_i,
  input  logic            we0_i,
  input  logic [AW-1:0]   wa0_i,
  input  logic [DW-1:0]   wd0_i,
  input  logic            we1_i,
  input  logic [AW-1:0]   wa1_i,
  input  logic [DW-1:0]   wd1_i,
  output logic [DW-1:0]   rd_data_o,
  output logic            rd_pend_o
);

  import mips_pkg::*;

  localparam logic [AW-1:0] ZeroAddr = AW'(REG_ZERO);

  logic          addrNonZero;
  logic          hit0;
  logic          hit1;
  logic [DW-1:0] rdData_d;
  logic [DW-1:0] rdData_q;

  assign addrNonZero = (rd_addr_i != ZeroAddr);
  assign hit0 = BYPASS && we0_i && (wa0_i == rd_addr_i) && addrNonZero;
  assign hit1 = BYPASS && we1_i && (wa1_i == rd_addr_i) && addrNonZero;

  // Port 1 is the later pipeline stage, so it takes precedence in the bypass.
  always_comb begin
    rdData_d = '0;
    if (hit1) begin
      rdData_d = wd1_i;
    end else if (hit0) begin
      rdData_d = wd0_i;
    end else if (addrNonZero) begin
      rdData_d = stored_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdData_q <= '0;
    end else begin
      rdData_q <= rdData_d;
    end
  end

  assign rd_data_o = RD_REG ? rdData_q : rdData_d;
  assign rd_pend_o = pend_i[rd_addr_i] & ~(hit0 | hit1);

endmodule

// File: rtl/multiport_register_file.sv
// MIPS GPR file with NRD read ports, two write ports, $0 hardwired to zero and
// a per-register pending scoreboard feeding the stall unit.
module multiport_register_file #(
  parameter int DW     = mips_pkg::DW,
  parameter int NREG   = mips_pkg::NREG,
  parameter int NRD    = 2,
  parameter bit BYPASS = 1'b1,
  parameter bit RD_REG = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*DW-1:0]           rd_data,
  output logic [NRD-1:0]              rd_pend,
  input  logic                        we0,
  input  logic [$clog2(NREG)-1:0]     wa0,
  input  logic [DW-1:0]               wd0,
  input  logic                        we1,
  input  logic [$clog2(NREG)-1:0]     wa1,
  input  logic [DW-1:0]               wd1,
  input  logic                        pend_set,
  input  logic [$clog2(NREG)-1:0]     pend_addr,
  output logic                        any_pend
);

  import mips_pkg::*;

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] ZeroAddr = AW'(REG_ZERO);

  logic [DW-1:0]   regs_q [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (we0 && (wa0 != ZeroAddr)) begin
        regs_q[wa0] <= wd0;
      end
      if (we1 && (wa1 != ZeroAddr)) begin
        regs_q[wa1] <= wd1;
      end
    end
  end

  // A new issue to the same register outranks a writeback clearing it.
  always_comb begin
    pend_d = '0;
    for (int r = 1; r < NREG; r++) begin
      pend_d[r] = (pend_q[r] & ~((we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)))))
                | (pend_set && (pend_addr == AW'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign any_pend = |pend_q;

  for (genvar i = 0; i < NRD; i++) begin : gen_rd
    regfile_read_port #(
      .DW    (DW),
      .NREG  (NREG),
      .AW    (AW),
      .BYPASS(BYPASS),
      .RD_REG(RD_REG)
    ) u_read_port (
      .clk_i    (clk),
      .rst_i    (rst),
      .rd_addr_i(rd_addr[i*AW +: AW]),
      .stored_i (regs_q[rd_addr[i*AW +: AW]]),
      .pend_i   (pend_q),
      .we0_i    (we0),
      .wa0_i    (wa0),
      .wd0_i    (wd0),
      .we1_i    (we1),
      .wa1_i    (wa1),
      .wd1_i    (wd1),
      .rd_data_o(rd_data[i*DW +: DW]),
      .rd_pend_o(rd_pend[i])
    );
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Drives two register files (bypass/combinational and no-bypass/registered)
// with the same stimulus and checks them against a reference model.
module tb_multiport_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rdAddr;
  logic        we0, we1, pendSet;
  logic [4:0]  wa0, wa1, pendAddr;
  logic [31:0] wd0, wd1;

  logic [63:0] rdDataA, rdDataB;
  logic [1:0]  rdPendA, rdPendB;
  logic        anyPendA, anyPendB;

  logic [31:0] modelRegs [32];
  logic [31:0] modelPend;
  logic [63:0] expQ [$];

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  multiport_register_file #(.BYPASS(1'b1), .RD_REG(1'b0)) dutA (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_pend(rdPendA),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .pend_set(pendSet), .pend_addr(pendAddr), .any_pend(anyPendA)
  );

  multiport_register_file #(.BYPASS(1'b0), .RD_REG(1'b1)) dutB (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_pend(rdPendB),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .pend_set(pendSet), .pend_addr(pendAddr), .any_pend(anyPendB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] bypassRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return modelRegs[a];
  endfunction

  function automatic logic writeHit(input logic [4:0] a);
    return (a != 5'd0) && ((we0 && wa0 == a) || (we1 && wa1 == a));
  endfunction

  // One clock cycle: drive at negedge, check outputs, then advance the model past the edge.
  task automatic applyStimulus(input logic r, input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic ps, input logic [4:0] pa);
    logic [4:0]  addr;
    logic [31:0] nextPend;
    @(negedge clk);
    rst = r; rdAddr = {ra1, ra0};
    we0 = e0; wa0 = a0; wd0 = d0;
    we1 = e1; wa1 = a1; wd1 = d1;
    pendSet = ps; pendAddr = pa;
    #1;
    for (int i = 0; i < 2; i++) begin
      addr = (i == 0) ? ra0 : ra1;
      checkOutput($sformatf("A.rd_data[%0d] r%0d", i, addr), {32'd0, rdDataA[i*32 +: 32]}, {32'd0, bypassRead(addr)});
      checkOutput($sformatf("A.rd_pend[%0d] r%0d", i, addr), {63'd0, rdPendA[i]}, {63'd0, modelPend[addr] & ~writeHit(addr)});
      checkOutput($sformatf("B.rd_pend[%0d] r%0d", i, addr), {63'd0, rdPendB[i]}, {63'd0, modelPend[addr]});
    end
    checkOutput("A.any_pend", {63'd0, anyPendA}, {63'd0, |modelPend});
    checkOutput("B.any_pend", {63'd0, anyPendB}, {63'd0, |modelPend});
    if (expQ.size() > 0) begin
      checkOutput("B.rd_data registered", rdDataB, expQ.pop_front());
    end
    expQ.push_back(r ? 64'd0 : {modelRegs[ra1], modelRegs[ra0]});
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 32; k++) modelRegs[k] = 32'd0;
      modelPend = 32'd0;
    end else begin
      nextPend = 32'd0;
      for (int k = 1; k < 32; k++) begin
        nextPend[k] = (modelPend[k] & ~writeHit(5'(k))) | (ps && pa == 5'(k));
      end
      modelPend = nextPend;
      if (e0 && a0 != 5'd0) modelRegs[a0] = d0;
      if (e1 && a1 != 5'd0) modelRegs[a1] = d1;
    end
  endtask

  initial begin
    rst = 1'b1; rdAddr = '0; we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
    pendSet = 0; pendAddr = 0;
    for (int k = 0; k < 32; k++) modelRegs[k] = 32'd0;
    modelPend = 32'd0;
    repeat (2) @(posedge clk);

    // Preload r5=55 and pend r7, then reset must wipe both.
    applyStimulus(0, 5, 7, 1, 5, 32'd55, 0, 0, 0, 1, 7);
    applyStimulus(0, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic write then read, with port 1 on $0.
    applyStimulus(0, 1, 0, 1, 1, 32'd55, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // $0 ignores writes and pend_set.
    applyStimulus(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Dual-write collision: port 1 wins.
    applyStimulus(0, 3, 3, 1, 3, 32'd10, 1, 3, 32'd20, 0, 0);
    applyStimulus(0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);

    // Bypass: read r4 while it is written.
    applyStimulus(0, 4, 1, 1, 4, 32'd7, 0, 0, 0, 0, 0);
    applyStimulus(0, 4, 1, 1, 4, 32'd99, 0, 0, 0, 0, 0);
    applyStimulus(0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Scoreboard: set, set+clear same cycle, lone clear.
    applyStimulus(0, 9, 3, 0, 0, 0, 0, 0, 0, 1, 9);
    applyStimulus(0, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 9, 3, 0, 0, 0, 1, 9, 32'h1234, 1, 9);
    applyStimulus(0, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 9, 3, 1, 9, 32'h5678, 0, 0, 0, 0, 0);
    applyStimulus(0, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0);

    // Pending writes dropped by a mid-operation reset.
    applyStimulus(1, 9, 4, 1, 9, 32'hAAAA, 1, 4, 32'hBBBB, 1, 12);
    applyStimulus(0, 9, 4, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small address window to force collisions.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(($urandom_range(0, 29) == 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
